// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display path.
// Segment constants are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   blink;
    logic                    lzs;
  } frame_t;

  // After reset every digit is blanked so the display stays dark until a frame arrives.
  localparam frame_t FRAME_RESET = '{data: '0, dp: '0, blank: '1, blink: '0, lzs: 1'b0};

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_t;

  // Marks digits 7..1 that are zero above the most significant non-zero nibble.
  function automatic logic [NUM_DIGITS-1:0] lzs_mask_f(input logic [4*NUM_DIGITS-1:0] data);
    logic [NUM_DIGITS-1:0] mask;
    logic                  leading;
    mask    = '0;
    leading = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (leading && (data[4*k +: 4] == 4'h0)) mask[k] = 1'b1;
      else leading = 1'b0;
    end
    return mask;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (hex)
      4'h0: seg_n = SEG_0;
      4'h1: seg_n = SEG_1;
      4'h2: seg_n = SEG_2;
      4'h3: seg_n = SEG_3;
      4'h4: seg_n = SEG_4;
      4'h5: seg_n = SEG_5;
      4'h6: seg_n = SEG_6;
      4'h7: seg_n = SEG_7;
      4'h8: seg_n = SEG_8;
      4'h9: seg_n = SEG_9;
      4'hA: seg_n = SEG_A;
      4'hB: seg_n = SEG_B;
      4'hC: seg_n = SEG_C;
      4'hD: seg_n = SEG_D;
      4'hE: seg_n = SEG_E;
      4'hF: seg_n = SEG_F;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_buffer.sv
// Double-buffered 8-digit display frame; commits on the scan wrap (seg_sel 7 -> 0).
//   state      | meaning
//   ST_IDLE    | no frame pending, load is accepted
//   ST_PENDING | shadow frame waiting for the seg_sel=7 tick
module seg_display_buffer
  import seg_pkg::*;
#(
  parameter int unsigned BLINK_TICKS = 240
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic [2:0]              seg_sel,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    lzs_en,
  output logic                    busy,
  output logic                    frame_done,
  output logic [6:0]              seg_n,
  output logic                    dp_n
);

  localparam logic [15:0] BLINK_LAST = 16'(BLINK_TICKS - 1);

  commit_state_t         state, state_nxt;
  frame_t                shadow, active;
  logic [NUM_DIGITS-1:0] lzs_mask;
  logic [15:0]           blink_cnt;
  logic                  blink_phase;
  logic                  commit, accept, dark;
  logic [3:0]            nibble;
  logic [6:0]            seg_dec;

  assign busy   = (state == ST_PENDING);
  assign commit = busy && tick && (seg_sel == 3'd7);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          accept    = 1'b1;
          state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: if (commit) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      shadow     <= '0;
      active     <= FRAME_RESET;
      lzs_mask   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= commit;
      if (accept)
        shadow <= '{data: din, dp: dp_in, blank: blank_in, blink: blink_in, lzs: lzs_en};
      if (commit) begin
        active   <= shadow;
        lzs_mask <= lzs_mask_f(shadow.data);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt >= BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  // The mask is always computed at commit; the latched lzs flag decides whether it applies.
  assign nibble = active.data[{seg_sel, 2'b00} +: 4];
  assign dark   = active.blank[seg_sel]
               || (active.lzs && lzs_mask[seg_sel])
               || (active.blink[seg_sel] && blink_phase);

  hex_to_seg7 u_dec (
    .hex   (nibble),
    .seg_n (seg_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else begin
      seg_n <= dark ? SEG_BLANK : seg_dec;
      dp_n  <= dark ? 1'b1 : ~active.dp[seg_sel];
    end
  end

endmodule

// File: tb/tb_seg_display_buffer.sv
// Directed bench for seg_display_buffer with a frame model and an expected-output queue.
module tb_seg_display_buffer;

  localparam int BT = 4;

  logic        clk = 1'b0;
  logic        reset, tick, load, lzs_en;
  logic [2:0]  seg_sel;
  logic [31:0] din;
  logic [7:0]  dp_in, blank_in, blink_in;
  logic        busy, frame_done, dp_n;
  logic [6:0]  seg_n;

  always #5 clk = ~clk;

  seg_display_buffer #(.BLINK_TICKS(BT)) dut (
    .clk(clk), .reset(reset), .tick(tick), .seg_sel(seg_sel), .load(load),
    .din(din), .dp_in(dp_in), .blank_in(blank_in), .blink_in(blink_in),
    .lzs_en(lzs_en), .busy(busy), .frame_done(frame_done), .seg_n(seg_n), .dp_n(dp_n)
  );

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    string      tag;
    logic [6:0] seg;
    logic       dp;
  } exp_t;
  exp_t sb[$];

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] a_data, s_data;
  logic [7:0]  a_dp, a_blank, a_blink, s_dp, s_blank, s_blink;
  logic        a_lzs, s_lzs, m_busy;
  int          n_ticks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    a_data = '0; a_dp = '0; a_blank = 8'hFF; a_blink = '0; a_lzs = 1'b0;
    s_data = '0; s_dp = '0; s_blank = '0; s_blink = '0; s_lzs = 1'b0;
    m_busy = 1'b0; n_ticks = 0;
  endtask

  task automatic model_out(input int d, output logic [6:0] s, output logic p);
    int   top;
    logic drk;
    top = 0;
    for (int k = 0; k < 8; k++) if (a_data[4*k +: 4] != 4'h0) top = k;
    drk = a_blank[d] || (a_lzs && d > top) || (a_blink[d] && ((n_ticks / BT) % 2 == 1));
    s = drk ? 7'h7F : dec_tab[a_data[4*d +: 4]];
    p = drk ? 1'b1 : ~a_dp[d];
  endtask

  task automatic show(input int d, input string tag);
    exp_t e;
    model_out(d, e.seg, e.dp);
    e.tag = tag;
    sb.push_back(e);
    seg_sel = 3'(d); tick = 1'b0;
    @(posedge clk); #1;
    e = sb.pop_front();
    check({e.tag, "_seg"}, 32'(seg_n), 32'(e.seg));
    check({e.tag, "_dp"}, 32'(dp_n), 32'(e.dp));
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl,
                         input logic [7:0] bk, input logic lz);
    load = 1'b1; din = d; dp_in = dp; blank_in = bl; blink_in = bk; lzs_en = lz; tick = 1'b0;
    if (!m_busy) begin
      s_data = d; s_dp = dp; s_blank = bl; s_blink = bk; s_lzs = lz; m_busy = 1'b1;
    end
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic do_tick(input int sel);
    seg_sel = 3'(sel); tick = 1'b1;
    @(posedge clk);
    n_ticks++;
    if (m_busy && sel == 7) begin
      a_data = s_data; a_dp = s_dp; a_blank = s_blank; a_blink = s_blink; a_lzs = s_lzs;
      m_busy = 1'b0;
    end
    #1;
    tick = 1'b0;
  endtask

  initial begin
    model_reset();
    reset = 1'b1; tick = 1'b1; load = 1'b1; lzs_en = 1'b1; seg_sel = '0;
    din = $urandom; dp_in = 8'hA5; blank_in = 8'h00; blink_in = 8'h3C;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 8; d++) begin
      show(d, "reset");
      check("reset_busy", 32'(busy), 32'd0);
    end
    check("reset_fd", 32'(frame_done), 32'd0);
    tick = 1'b0; load = 1'b0; lzs_en = 1'b0; reset = 1'b0;
    show(3, "post_reset");

    // basic commit and busy rejection
    seg_sel = 3'd3;
    do_load(32'h76543210, 8'h00, 8'h00, 8'h00, 1'b0);
    check("load_busy", 32'(busy), 32'd1);
    do_tick(3);
    do_tick(4);
    check("no_commit_sel4", 32'(busy), 32'd1);
    do_load(32'hFFFFFFFF, 8'hFF, 8'h00, 8'h00, 1'b0);
    check("reject_busy", 32'(busy), 32'd1);
    do_tick(5);
    do_tick(6);
    check("no_fd_early", 32'(frame_done), 32'd0);
    do_tick(7);
    check("commit_busy", 32'(busy), 32'd0);
    check("commit_fd", 32'(frame_done), 32'd1);
    show(3, "basic_d3");
    check("fd_one_clk", 32'(frame_done), 32'd0);
    for (int d = 0; d < 8; d++) show(d, "basic");

    // leading-zero suppression
    do_load(32'h00000A05, 8'h00, 8'h00, 8'h00, 1'b1);
    do_tick(7);
    check("lzs_fd", 32'(frame_done), 32'd1);
    for (int d = 0; d < 8; d++) show(d, "lzs_a05");
    do_load(32'h00000000, 8'h00, 8'h00, 8'h00, 1'b1);
    do_tick(7);
    for (int d = 0; d < 8; d++) show(d, "lzs_zero");

    // blink and decimal point
    do_load(32'h00000018, 8'h01, 8'h00, 8'h01, 1'b0);
    do_tick(7);
    for (int i = 0; i < 16; i++) begin
      do_tick(1);
      show(0, "blink_d0");
    end
    show(1, "blink_d1");

    // reset while a frame is pending
    do_load(32'h12345678, 8'hFF, 8'h00, 8'h00, 1'b0);
    check("pend_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_seg", 32'(seg_n), 32'h7F);
    check("async_dp", 32'(dp_n), 32'd1);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    do_tick(7);
    check("rst_no_fd", 32'(frame_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    show(0, "rst_d0");
    show(5, "rst_d5");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg_display_buffer.md
# seg_display_buffer

Downstream companion of the anode-scanning controller: consumes its 3-bit digit select (`seg_sel`) and the shared 480 Hz scan `tick`, and drives the active-low cathodes (`seg_n`, `dp_n`) of the 8-digit seven-segment display. It holds a double-buffered 8-digit hex frame with per-digit blank, decimal point and blink controls, plus optional leading-zero suppression. New frames are committed only at a scan-frame boundary, so the display never shows a half-updated frame.

## Interface
- `BLINK_TICKS`, default 240: scan ticks per blink half-period (0.5 s at 480 Hz); legal range 1..65535.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `tick`  in  1  one-clk scan strobe; the same signal that advances the anode controller.
- `seg_sel`  in  3  digit currently selected by the anode controller; 0 is the rightmost digit.
- `load`  in  1  request to write the shadow frame; accepted only when `busy`=0.
- `din`  in  32  8 hex nibbles; nibble *k* is `din[4k+3:4k]` and belongs to digit *k*.
- `dp_in`  in  8  decimal point on, one bit per digit.
- `blank_in`  in  8  force digit dark, one bit per digit.
- `blink_in`  in  8  digit blinks, one bit per digit.
- `lzs_en`  in  1  enable leading-zero suppression; latched with the frame.
- `busy`  out  1  a shadow frame is pending commit.
- `frame_done`  out  1  one-clk pulse on the clk after a commit.
- `seg_n`  out  7  cathodes `{g,f,e,d,c,b,a}`, active-low.
- `dp_n`  out  1  decimal-point cathode, active-low.

## Operation
- **Shadow write.** When `load`=1 and `busy`=0, the shadow register captures `din`, `dp_in`, `blank_in`, `blink_in` and `lzs_en`, and `busy` goes to 1.
  - A `load` asserted while `busy`=1 is ignored, with no side effects.
- **Commit.** The commit happens on the clk where `busy`=1, `tick`=1 and `seg_sel`=7, i.e. the edge on which the controller wraps to digit 0.
  - Shadow is copied to active, `busy` clears, and `frame_done` pulses on the following clk.
- **Leading-zero suppression.** The suppression mask is computed from the shadow data at commit.
  - When `lzs_en`=1, digits 7 down to 1 are suppressed while their nibble is 0, stopping at the first non-zero nibble.
  - Digit 0 is never suppressed.
- **Blink.** A 16-bit counter increments on each `tick`. At `BLINK_TICKS`-1 it wraps to 0 and toggles `blink_phase`.
- **Digit output.** For digit d = `seg_sel`, the digit is dark if `blank`[d], or `lzs_mask`[d], or (`blink`[d] & `blink_phase`). Otherwise:
  - `seg_n` = decode(nibble d);
  - `dp_n` = ~`dp`[d].
- **Dark digit.** `seg_n`=7'h7F and `dp_n`=1. The decimal point is also dark.
- **Decode (active-low).**
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (hex)
- **Reset values.**
  - Active: data 0, `dp` 0, `blank` 8'hFF, `blink` 0, `lzs` 0.
  - Shadow cleared, `busy`=0, `frame_done`=0.
  - Blink counter 0, `blink_phase`=0.
  - `seg_n`=7'h7F, `dp_n`=1.

## Timing
- `seg_n`/`dp_n` are registered: they reflect `seg_sel` and active state sampled at the previous clk edge, a 1-clk lag after each anode change (negligible at 480 Hz).
- `load`→`busy`: 1 clk.
- Commit latency after accept: up to 8 ticks. A load accepted on the commit edge itself is impossible, because `busy` is already 0 only if no commit is pending.
- A load accepted on the same clk as a non-commit tick is held until the next `seg_sel`=7 tick.
- Simultaneous commit and blink wrap: both take effect on the same edge, independently.
- `reset` mid-frame discards any pending shadow frame and returns to the reset values immediately (asynchronously).
- `tick` with `seg_sel`≠7 never commits, even with `busy`=1.

## Structure
- Shared package `seg_pkg`:
  - `NUM_DIGITS`=8;
  - `SEG_BLANK`=7'h7F;
  - the 16 active-low segment constants;
  - a frame struct/typedef {data[31:0], dp, blank, blink, lzs}.
- One sub-module: `hex_to_seg7` (combinational 4-bit → 7-bit active-low decoder).
- Parent holds shadow/active frames, commit FSM (IDLE/PENDING), lzs mask, blink counter and output registers.

## Test plan
- **Reset.** Assert reset with arbitrary inputs → `seg_n`=7F, `dp_n`=1, `busy`=0 for all `seg_sel`.
- **Basic commit.** Load `din`=32'h76543210, `blank_in`=0 mid-frame → `busy`=1; commit only at `seg_sel`=7 tick; `frame_done` pulse 1 clk later; `seg_sel`=3 then yields `seg_n`=30.
- **Busy rejection.** Second load while `busy`=1 with `din`=32'hFFFFFFFF → ignored; displayed digits remain 76543210 after commit.
- **Leading-zero suppression.** `lzs_en`=1, `din`=32'h00000A05 → digits 7..3 dark, digit 2 shows 08, digit 1 shows 40, digit 0 shows 12; `din`=0 → only digit 0 lit (40).
- **Blink and decimal point.** `BLINK_TICKS`=4, `blink_in`=8'h01, `dp_in`=8'h01 → digit 0 lit with `dp_n`=0 for 4 ticks, then dark (`dp_n`=1) for 4 ticks, repeating.
- **Reset mid-pending.** Load accepted, then reset asserted before the commit tick → `busy`=0, display dark, no `frame_done` pulse.
